// File: rtl/toy_bus_pkg.sv
// rtl/toy_bus_pkg.sv - ToyBusReq field widths, opcodes and lock-state encoding
package toy_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int STRB_W = 4;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam logic [0:0] LK_UNLOCKED = 1'b0;
    localparam logic [0:0] LK_LOCKED   = 1'b1;

endpackage

// File: rtl/toy_bus_CmnAgeMtx_nin.sv
// rtl/toy_bus_CmnAgeMtx_nin.sv - N-input age matrix; old[i][j]=1 means i is older than j
module toy_bus_CmnAgeMtx_nin #(
    parameter int N_IN = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN-1:0]        update_en,
    output logic [N_IN*N_IN-1:0]   old_rows
);

    // Reset order: lower index is older than every higher index.
    function automatic logic [N_IN*N_IN-1:0] age_rst();
        logic [N_IN*N_IN-1:0] v;
        v = '0;
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_IN; j++)
                if (i < j) v[i*N_IN+j] = 1'b1;
        return v;
    endfunction

    localparam logic [N_IN*N_IN-1:0] OLD_RST = age_rst();

    logic [N_IN*N_IN-1:0] r_old;

    // A granted requester becomes youngest: its row clears, its column sets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_old <= OLD_RST;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (update_en[i]) begin
                    for (int j = 0; j < N_IN; j++) begin
                        if (j != i) begin
                            r_old[i*N_IN+j] <= 1'b0;
                            r_old[j*N_IN+i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign old_rows = r_old;

endmodule

// File: rtl/toy_bus_req_arb_lock_fwd.sv
// rtl/toy_bus_req_arb_lock_fwd.sv - LRG arbiter with requester lock and registered forward slice; optional TOY_BUS_ARB_GNT_CNT_EN grant counters
module toy_bus_req_arb_lock_fwd
    import toy_bus_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN-1:0]         in_vld,
    output logic [N_IN-1:0]         in_rdy,
    input  logic [N_IN-1:0]         in_lock,
    input  logic [N_IN*ADDR_W-1:0]  in_addr,
    input  logic [N_IN*STRB_W-1:0]  in_strb,
    input  logic [N_IN*DATA_W-1:0]  in_data,
    input  logic [N_IN-1:0]         in_opcode,
    input  logic [N_IN*ID_W-1:0]    in_src_id,
    input  logic [N_IN*ID_W-1:0]    in_tgt_id,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [STRB_W-1:0]       out_strb,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_opcode,
    output logic [ID_W-1:0]         out_src_id,
    output logic [ID_W-1:0]         out_tgt_id,
    output logic [IDX_W-1:0]        out_port,
    output logic                    lock_active,
    output logic [IDX_W-1:0]        lock_owner
`ifdef TOY_BUS_ARB_GNT_CNT_EN
    ,
    input  logic                    gnt_cnt_clr,
    output logic [N_IN*16-1:0]      gnt_cnt
`endif
);

    logic [N_IN*N_IN-1:0] w_old;
    logic [N_IN-1:0]      w_blk;
    logic [N_IN-1:0]      w_sel;
    logic [N_IN-1:0]      w_hs;
    logic                 w_any_hs;
    logic                 w_accept;
    logic [IDX_W-1:0]     w_hs_idx;
    logic                 w_hs_lock;
    logic [ADDR_W-1:0]    w_addr;
    logic [STRB_W-1:0]    w_strb;
    logic [DATA_W-1:0]    w_data;
    logic                 w_opcode;
    logic [ID_W-1:0]      w_src_id;
    logic [ID_W-1:0]      w_tgt_id;

    logic [0:0]           r_lock_state;
    logic [IDX_W-1:0]     r_lock_owner;
    logic                 r_out_vld;
    logic [ADDR_W-1:0]    r_addr;
    logic [STRB_W-1:0]    r_strb;
    logic [DATA_W-1:0]    r_data;
    logic                 r_opcode;
    logic [ID_W-1:0]      r_src_id;
    logic [ID_W-1:0]      r_tgt_id;
    logic [IDX_W-1:0]     r_out_port;

    toy_bus_CmnAgeMtx_nin #(.N_IN(N_IN)) u_age (
        .clk       (clk),
        .rst_n     (rst_n),
        .update_en (w_hs),
        .old_rows  (w_old)
    );

    // Requester i is blocked if any other valid requester is older than it.
    always_comb begin
        w_blk = '0;
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_IN; j++)
                if (j != i && in_vld[j] && w_old[j*N_IN+i]) w_blk[i] = 1'b1;
    end

    // Select: oldest valid when unlocked, only the owner when locked.
    always_comb begin
        w_sel = '0;
        if (r_lock_state == LK_LOCKED)
            w_sel[r_lock_owner] = in_vld[r_lock_owner];
        else
            w_sel = in_vld & ~w_blk;
    end

    assign w_accept = ~r_out_vld | out_rdy;
    assign in_rdy   = w_sel & {N_IN{w_accept}};
    assign w_hs     = in_vld & in_rdy;
    assign w_any_hs = |w_hs;

    // One-hot payload mux and index encode of the handshaking requester.
    always_comb begin
        w_hs_idx  = '0;
        w_hs_lock = 1'b0;
        w_addr    = '0;
        w_strb    = '0;
        w_data    = '0;
        w_opcode  = OP_RD;
        w_src_id  = '0;
        w_tgt_id  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_hs[i]) begin
                w_hs_idx  = IDX_W'(i);
                w_hs_lock = in_lock[i];
                w_addr    = in_addr[ADDR_W*i +: ADDR_W];
                w_strb    = in_strb[STRB_W*i +: STRB_W];
                w_data    = in_data[DATA_W*i +: DATA_W];
                w_opcode  = in_opcode[i];
                w_src_id  = in_src_id[ID_W*i +: ID_W];
                w_tgt_id  = in_tgt_id[ID_W*i +: ID_W];
            end
        end
    end

    // Lock FSM: in_lock only matters on a handshake beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_state <= LK_UNLOCKED;
            r_lock_owner <= '0;
        end else if (w_any_hs) begin
            if (w_hs_lock) begin
                r_lock_state <= LK_LOCKED;
                r_lock_owner <= w_hs_idx;
            end else begin
                r_lock_state <= LK_UNLOCKED;
                r_lock_owner <= '0;
            end
        end
    end

    // Output slice: load on handshake, drain on out_rdy, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_addr     <= '0;
            r_strb     <= '0;
            r_data     <= '0;
            r_opcode   <= OP_RD;
            r_src_id   <= '0;
            r_tgt_id   <= '0;
            r_out_port <= '0;
        end else if (w_any_hs) begin
            r_out_vld  <= 1'b1;
            r_addr     <= w_addr;
            r_strb     <= w_strb;
            r_data     <= w_data;
            r_opcode   <= w_opcode;
            r_src_id   <= w_src_id;
            r_tgt_id   <= w_tgt_id;
            r_out_port <= w_hs_idx;
        end else if (out_rdy) begin
            r_out_vld  <= 1'b0;
        end
    end

    assign out_vld     = r_out_vld;
    assign out_addr    = r_addr;
    assign out_strb    = r_strb;
    assign out_data    = r_data;
    assign out_opcode  = r_opcode;
    assign out_src_id  = r_src_id;
    assign out_tgt_id  = r_tgt_id;
    assign out_port    = r_out_port;
    assign lock_active = (r_lock_state == LK_LOCKED);
    assign lock_owner  = r_lock_owner;

`ifdef TOY_BUS_ARB_GNT_CNT_EN
    logic [15:0] r_gnt_cnt [N_IN];

    // Per-requester saturating grant counters; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) r_gnt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (gnt_cnt_clr)
                    r_gnt_cnt[i] <= '0;
                else if (w_hs[i] && r_gnt_cnt[i] != 16'hFFFF)
                    r_gnt_cnt[i] <= r_gnt_cnt[i] + 16'd1;
            end
        end
    end

    // Flatten counters, requester i at [16i+:16].
    always_comb begin
        gnt_cnt = '0;
        for (int i = 0; i < N_IN; i++) gnt_cnt[16*i +: 16] = r_gnt_cnt[i];
    end
`endif

endmodule

// File: tb/tb_toy_bus_req_arb_lock_fwd.sv
// tb/tb_toy_bus_req_arb_lock_fwd.sv - directed self-checking bench for toy_bus_req_arb_lock_fwd
module tb_toy_bus_req_arb_lock_fwd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_vld, in_rdy, in_lock, in_opcode;
    logic [63:0] in_addr, in_data;
    logic [7:0]  in_strb, in_src_id, in_tgt_id;
    logic        out_vld, out_rdy, out_opcode;
    logic [31:0] out_addr, out_data;
    logic [3:0]  out_strb, out_src_id, out_tgt_id;
    logic        out_port, lock_active, lock_owner;
`ifdef TOY_BUS_ARB_GNT_CNT_EN
    logic        gnt_cnt_clr;
    logic [31:0] gnt_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    toy_bus_req_arb_lock_fwd #(.N_IN(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .in_lock     (in_lock),
        .in_addr     (in_addr),
        .in_strb     (in_strb),
        .in_data     (in_data),
        .in_opcode   (in_opcode),
        .in_src_id   (in_src_id),
        .in_tgt_id   (in_tgt_id),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_addr    (out_addr),
        .out_strb    (out_strb),
        .out_data    (out_data),
        .out_opcode  (out_opcode),
        .out_src_id  (out_src_id),
        .out_tgt_id  (out_tgt_id),
        .out_port    (out_port),
        .lock_active (lock_active),
        .lock_owner  (lock_owner)
`ifdef TOY_BUS_ARB_GNT_CNT_EN
        ,
        .gnt_cnt_clr (gnt_cnt_clr),
        .gnt_cnt     (gnt_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [31:0] a0, input logic [31:0] a1);
        in_addr = {a1, a0};
        in_data = {~a1, ~a0};
    endtask

    initial begin
        rst_n     = 1'b0;
        in_vld    = 2'b00;
        in_lock   = 2'b00;
        in_opcode = 2'b10;
        in_strb   = 8'hC3;
        in_src_id = 8'h21;
        in_tgt_id = 8'h55;
        out_rdy   = 1'b0;
        set_addr(32'hA000_0000, 32'hB000_0000);
`ifdef TOY_BUS_ARB_GNT_CNT_EN
        gnt_cnt_clr = 1'b0;
`endif
        #12;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_lock_active", lock_active, 0);
        chk("rst_lock_owner", lock_owner, 0);
        chk("rst_out_port", out_port, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_in_rdy", in_rdy, 0);
        tick();
        rst_n = 1'b1;

        // Both requesting: reset age grants 0 first, then alternate.
        in_vld  = 2'b11;
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("alt_in_rdy", in_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("alt_out_port", out_port, k % 2);
            chk("alt_out_vld", out_vld, 1);
        end
        chk("alt_out_addr", out_addr, 32'hB000_0000);
        chk("alt_out_data", out_data, ~32'hB000_0000);
        chk("alt_out_src", out_src_id, 4'h2);
        chk("alt_out_op", out_opcode, 1);

        // in0 streams alone, then in1 joins and wins since in0 is youngest.
        in_vld = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("strm_out_port", out_port, 0);
            chk("strm_out_vld", out_vld, 1);
        end
        in_vld = 2'b11;
        #1;
        chk("strm_join_rdy", in_rdy, 2'b10);
        tick();
        chk("strm_join_port", out_port, 1);
        chk("strm_join_vld", out_vld, 1);
        in_vld = 2'b00;
        tick();
        chk("idle_out_vld", out_vld, 0);

        // Locked three-beat sequence from in1 while in0 waits.
        in_vld  = 2'b10;
        in_lock = 2'b10;
        tick();
        chk("lk1_active", lock_active, 1);
        chk("lk1_owner", lock_owner, 1);
        chk("lk1_port", out_port, 1);
        in_vld = 2'b11;
        #1;
        chk("lk2_in_rdy", in_rdy, 2'b10);
        tick();
        chk("lk2_active", lock_active, 1);
        chk("lk2_owner", lock_owner, 1);
        in_lock = 2'b00;
        #1;
        chk("lk3_in_rdy", in_rdy, 2'b10);
        tick();
        chk("lk3_port", out_port, 1);
        chk("unlk_active", lock_active, 0);
        chk("unlk_owner", lock_owner, 0);
        #1;
        chk("unlk_in_rdy", in_rdy, 2'b01);
        in_vld = 2'b01;
        set_addr(32'h1000_0040, 32'hB000_0000);
        tick();
        chk("unlk_port", out_port, 0);
        chk("bp_load_addr", out_addr, 32'h1000_0040);

        // Backpressure: payload frozen, no readies; release loads same cycle.
        out_rdy = 1'b0;
        set_addr(32'h2000_0000, 32'hB000_0000);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_rdy", in_rdy, 2'b00);
            tick();
            chk("bp_out_addr", out_addr, 32'h1000_0040);
            chk("bp_out_vld", out_vld, 1);
        end
        out_rdy = 1'b1;
        #1;
        chk("bp_rel_in_rdy", in_rdy, 2'b01);
        tick();
        chk("bp_rel_addr", out_addr, 32'h2000_0000);
        chk("bp_rel_vld", out_vld, 1);

        // Reset while locked to in1 with a beat in flight.
        in_vld  = 2'b10;
        in_lock = 2'b10;
        tick();
        chk("prst_active", lock_active, 1);
        chk("prst_vld", out_vld, 1);
        out_rdy = 1'b0;
        in_vld  = 2'b00;
        in_lock = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_vld", out_vld, 0);
        chk("mrst_active", lock_active, 0);
        tick();
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        in_vld  = 2'b11;
        #1;
        chk("post_rst_in_rdy", in_rdy, 2'b01);
        tick();
        chk("post_rst_port", out_port, 0);
        chk("post_rst_addr", out_addr, 32'h2000_0000);
        chk("post_rst_vld", out_vld, 1);

`ifdef TOY_BUS_ARB_GNT_CNT_EN
        in_vld      = 2'b00;
        gnt_cnt_clr = 1'b1;
        tick();
        gnt_cnt_clr = 1'b0;
        in_vld      = 2'b01;
        for (int k = 0; k < 70000; k++) @(posedge clk);
        #1;
        chk("cnt_sat", gnt_cnt[15:0], 16'hFFFF);
        chk("cnt_other", gnt_cnt[31:16], 16'h0000);
        gnt_cnt_clr = 1'b1;
        tick();
        chk("cnt_clr", gnt_cnt[15:0], 16'h0000);
        gnt_cnt_clr = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/toy_bus_req_arb_lock_fwd.md
Name: toy_bus_req_arb_lock_fwd

Overview:
- N-input arbiter for ToyBusReq traffic (LSU/debug/DMA masters) sharing one bus-node output port.
- Age-matrix least-recently-granted arbitration.
- Requester-driven lock keeps the grant on one master for atomic multi-beat sequences.
- Registered forward output slice with full throughput. Sits in the bus network in front of the target decoder.

Parameters:
- N_IN, 2, number of requesters; legal range 2..8.
- IDX_W, $clog2(N_IN), width of granted-port index.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_vld  in  N_IN  per-requester valid
- in_rdy  out  N_IN  per-requester ready
- in_lock  in  N_IN  hold grant after this beat
- in_addr  in  N_IN*32  flattened, requester i at [32i+:32]
- in_strb  in  N_IN*4  byte strobes
- in_data  in  N_IN*32  write data
- in_opcode  in  N_IN  0=read, 1=write
- in_src_id  in  N_IN*4  source id
- in_tgt_id  in  N_IN*4  target id
- out_vld  out  1  registered valid
- out_rdy  in  1  downstream ready
- out_addr/out_strb/out_data/out_opcode/out_src_id/out_tgt_id  out  32/4/32/1/4/4  registered payload
- out_port  out  IDX_W  index of requester that produced the current out beat
- lock_active  out  1  arbiter locked to lock_owner
- lock_owner  out  IDX_W  current lock owner, 0 when unlocked

Behaviour:
- Reset values: all outputs 0.
  - Age matrix reset: old[i][j]=1 for i<j, so index 0 is oldest.
  - Lock state reset: UNLOCKED.
- accept = ~out_vld | out_rdy. The slot frees in the same cycle it drains.
- UNLOCKED state:
  - sel[i] = in_vld[i] & ~OR over j≠i of (in_vld[j] & old[j][i]).
  - Exactly one sel bit is set when any in_vld is high.
  - in_rdy[i] = sel[i] & accept. in_rdy is combinational from in_vld and out_rdy; there is no combinational path from payload.
- LOCKED(owner) state:
  - sel = in_vld[owner] only; all other in_rdy=0.
  - Non-owners stay pending, and their age is untouched.
- Handshake on i (in_vld[i] & in_rdy[i]):
  - Payload is captured into the out register, out_vld<=1, out_port<=i.
  - Age update: row i cleared and column i set, so i becomes youngest.
- State transitions:
  - UNLOCKED->LOCKED(i): on handshake of i with in_lock[i]=1.
  - LOCKED->UNLOCKED: on owner handshake with in_lock=0.
  - Owner handshake with in_lock=1 stays LOCKED.
  - lock_active/lock_owner are registered and reflect the state.
- No handshake and out_rdy=1: out_vld<=0.
- No handshake and out_rdy=0: hold. Payload is stable while out_vld & ~out_rdy.
- Latency is 1 cycle from input handshake to out_vld. Sustained throughput is 1 beat/cycle.
- Simultaneous drain and load in one cycle: new beat replaces old, out_vld stays 1.
- Lock owner deasserting in_vld while LOCKED: lock holds and the output idles. There is no timeout.
- in_lock is sampled only on the owning handshake beat.
- Reset mid-lock: asynchronous return to UNLOCKED and the reset age order. An in-flight out beat is dropped.
- in_vld must stay high until handshake; dropping it earlier is a protocol violation and not checked.

Optional Feature:
- Macro TOY_BUS_ARB_GNT_CNT_EN.
- Defined:
  - Adds ports gnt_cnt_clr (in, 1) and gnt_cnt (out, N_IN*16).
  - One 16-bit counter per requester, incremented on its handshake, saturating at 16'hFFFF.
  - Synchronous clear via gnt_cnt_clr; clear wins over a same-cycle increment.
  - Counters reset to 0.
- Undefined: ports and counters are absent; arbitration behaviour is identical.

Decomposition:
- Package toy_bus_pkg:
  - ToyBusReq field widths: ADDR_W=32, STRB_W=4, DATA_W=32, ID_W=4.
  - Opcode constants: RD=0, WR=1.
  - Lock state encoding: UNLOCKED/LOCKED.
- Sub-module: the existing toy_bus_CmnAgeMtx generalized as toy_bus_CmnAgeMtx_nin.
  - Inputs: update_en[N_IN].
  - Output: flattened age rows.
  - Instantiated once.
- Lock FSM, select and output slice live in the top module.

Test Plan:
- Reset, then in_vld=2'b11 held with out_rdy=1 -> in0 granted first (out_port=0), then in1. Further alternation is 0,1,0,1.
- in0 alone streams 4 beats, then in1 rises -> in1 granted on the next cycle (in0 is youngest). out_vld is continuous with no bubble.
- in1 sends 3 beats with in_lock=1,1,0 while in0_vld=1 -> in0_rdy=0 for all three; lock_active=1, lock_owner=1 during the sequence; in0 granted on the 4th cycle.
- out_rdy=0 for 5 cycles with out beat addr=32'h1000_0040 -> out payload stable, all in_rdy=0. When out_rdy rises, a new beat loads in the same cycle.
- rst_n asserted while LOCKED(1) with out_vld=1 -> out_vld=0 and lock_active=0 immediately. Then in_vld=11 -> in0 granted first.
- With TOY_BUS_ARB_GNT_CNT_EN defined:
  - 70000 in0 handshakes -> gnt_cnt[15:0]=16'hFFFF.
  - gnt_cnt_clr concurrent with a handshake -> 0.
